// File: rtl/int_sequencer_if.sv
// Memory port B override bundle driven by the interrupt sequencer.
// The master side owns address/write controls; the slave (memory) returns asynchronous read data.
interface int_sequencer_if;
    logic       mem_b_sel;
    logic [7:0] mem_b_addr;
    logic       mem_b_we;
    logic [7:0] mem_b_wdata;
    logic [7:0] mem_rdata;

    modport master (
        output mem_b_sel,
        output mem_b_addr,
        output mem_b_we,
        output mem_b_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_b_sel,
        input  mem_b_addr,
        input  mem_b_we,
        input  mem_b_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/int_sequencer.sv
// Interrupt sequencer: freezes fetch, drains the pipe, pushes the return PC and loads the ISR vector.
// Optional macro INT_CCR_SAVE_EN adds a CCR push state and CCR restore on RTI.
module int_sequencer #(
    parameter int         DRAIN_CYCLES = 3,
    parameter logic [7:0] VECTOR_ADDR  = 8'h01
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   int_req,
    input  logic [7:0]             ret_pc,
    input  logic [7:0]             sp_value,
    input  logic [3:0]             ccr_in,
    input  logic                   rti_done,
    int_sequencer_if.master        mem_b,
    output logic                   pc_write_en,
    output logic                   if_id_write_en,
    output logic                   inject_bubble,
    output logic                   sp_en,
    output logic                   sp_op,
    output logic                   pc_load,
    output logic [7:0]             pc_load_val,
    output logic                   in_isr,
    output logic                   ccr_restore,
    output logic [3:0]             ccr_restore_val
);

    localparam int CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

`ifdef INT_CCR_SAVE_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_PUSH_PC,
        S_PUSH_CCR,
        S_VECTOR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_PUSH_PC,
        S_VECTOR
    } state_t;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] drain_cnt;
    logic [CNT_W-1:0] drain_cnt_nxt;
    logic             pending;
    logic             in_isr_q;
    logic             int_req_q;
    logic             int_rise;
    logic             enter_push;
    logic             rti_accept;

    assign int_rise   = int_req & ~int_req_q;
    assign enter_push = (state_nxt == S_PUSH_PC) && (state != S_PUSH_PC);
    assign rti_accept = rti_done & in_isr_q;
    assign in_isr     = in_isr_q;

    // A fresh edge wins over the clear so an event arriving on the entry cycle is not lost.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            drain_cnt <= '0;
            pending   <= 1'b0;
            in_isr_q  <= 1'b0;
            int_req_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            int_req_q <= int_req;
            if (int_rise) begin
                pending <= 1'b1;
            end else if (enter_push) begin
                pending <= 1'b0;
            end
            if (state == S_VECTOR) begin
                in_isr_q <= 1'b1;
            end else if (rti_accept) begin
                in_isr_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        case (state)
            S_IDLE: begin
                if (pending && !in_isr_q) begin
                    if (DRAIN_CYCLES > 0) begin
                        state_nxt     = S_DRAIN;
                        drain_cnt_nxt = CNT_W'(DRAIN_LOAD);
                    end else begin
                        state_nxt = S_PUSH_PC;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nxt = S_PUSH_PC;
                end else begin
                    drain_cnt_nxt = drain_cnt - 1'b1;
                end
            end
            S_PUSH_PC: begin
`ifdef INT_CCR_SAVE_EN
                state_nxt = S_PUSH_CCR;
`else
                state_nxt = S_VECTOR;
`endif
            end
`ifdef INT_CCR_SAVE_EN
            S_PUSH_CCR: state_nxt = S_VECTOR;
`endif
            S_VECTOR: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pc_write_en       = 1'b1;
        if_id_write_en    = 1'b1;
        inject_bubble     = 1'b0;
        mem_b.mem_b_sel   = 1'b0;
        mem_b.mem_b_addr  = 8'h00;
        mem_b.mem_b_we    = 1'b0;
        mem_b.mem_b_wdata = 8'h00;
        sp_en             = 1'b0;
        sp_op             = 1'b0;
        pc_load           = 1'b0;
        pc_load_val       = 8'h00;
        case (state)
            S_DRAIN: begin
                pc_write_en    = 1'b0;
                if_id_write_en = 1'b0;
                inject_bubble  = 1'b1;
            end
            S_PUSH_PC: begin
                pc_write_en       = 1'b0;
                if_id_write_en    = 1'b0;
                inject_bubble     = 1'b1;
                mem_b.mem_b_sel   = 1'b1;
                mem_b.mem_b_we    = 1'b1;
                mem_b.mem_b_addr  = sp_value;
                mem_b.mem_b_wdata = ret_pc;
                sp_en             = 1'b1;
            end
`ifdef INT_CCR_SAVE_EN
            S_PUSH_CCR: begin
                pc_write_en       = 1'b0;
                if_id_write_en    = 1'b0;
                inject_bubble     = 1'b1;
                mem_b.mem_b_sel   = 1'b1;
                mem_b.mem_b_we    = 1'b1;
                mem_b.mem_b_addr  = sp_value;
                mem_b.mem_b_wdata = {4'b0000, ccr_in};
                sp_en             = 1'b1;
            end
`endif
            // IF/ID is written with the bubble so the stale fetch is flushed as the PC jumps.
            S_VECTOR: begin
                pc_write_en      = 1'b0;
                if_id_write_en   = 1'b1;
                inject_bubble    = 1'b1;
                mem_b.mem_b_sel  = 1'b1;
                mem_b.mem_b_addr = VECTOR_ADDR;
                pc_load          = 1'b1;
                pc_load_val      = mem_b.mem_rdata;
            end
            default: begin
                pc_write_en    = 1'b1;
                if_id_write_en = 1'b1;
            end
        endcase
    end

`ifdef INT_CCR_SAVE_EN
    logic [3:0] ccr_shadow;

    always_ff @(posedge clk) begin
        if (state == S_PUSH_CCR) begin
            ccr_shadow <= ccr_in;
        end
    end

    assign ccr_restore     = rti_accept;
    assign ccr_restore_val = rti_accept ? ccr_shadow : 4'h0;
`else
    logic ccr_unused;
    assign ccr_unused      = ^ccr_in;
    assign ccr_restore     = 1'b0;
    assign ccr_restore_val = 4'h0;
`endif

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: per-cycle vector table plus scoreboarded port-B pushes and vector loads.
// Build with +define+INT_CCR_SAVE_EN to also cover the CCR save/restore path.
module tb_int_sequencer;
    localparam logic [7:0] VEC = 8'h01;
    localparam logic [7:0] ISR = 8'h80;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, int_req, rti_done, int_req0, rti_done0;
    logic [7:0] ret_pc, sp_value;
    logic [3:0] ccr_in;
    logic       pc_write_en, if_id_write_en, inject_bubble, sp_en, sp_op, pc_load, in_isr, ccr_restore;
    logic [7:0] pc_load_val;
    logic [3:0] ccr_restore_val;
    logic       pc_write_en0, if_id_write_en0, inject_bubble0, sp_en0, sp_op0, pc_load0, in_isr0, ccr_restore0;
    logic [7:0] pc_load_val0;
    logic [3:0] ccr_restore_val0;

    int_sequencer_if bus();
    int_sequencer_if bus0();

    // Memory model: only the vector location holds meaningful read data.
    assign bus.mem_rdata  = (bus.mem_b_addr == VEC) ? ISR : 8'h00;
    assign bus0.mem_rdata = (bus0.mem_b_addr == VEC) ? ISR : 8'h00;

    int_sequencer #(.DRAIN_CYCLES(3), .VECTOR_ADDR(VEC)) dut (
        .clk(clk), .rstn(rstn), .int_req(int_req), .ret_pc(ret_pc), .sp_value(sp_value),
        .ccr_in(ccr_in), .rti_done(rti_done), .mem_b(bus),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .inject_bubble(inject_bubble),
        .sp_en(sp_en), .sp_op(sp_op), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .in_isr(in_isr), .ccr_restore(ccr_restore), .ccr_restore_val(ccr_restore_val)
    );

    int_sequencer #(.DRAIN_CYCLES(0), .VECTOR_ADDR(VEC)) dut0 (
        .clk(clk), .rstn(rstn), .int_req(int_req0), .ret_pc(ret_pc), .sp_value(8'h40),
        .ccr_in(ccr_in), .rti_done(rti_done0), .mem_b(bus0),
        .pc_write_en(pc_write_en0), .if_id_write_en(if_id_write_en0), .inject_bubble(inject_bubble0),
        .sp_en(sp_en0), .sp_op(sp_op0), .pc_load(pc_load0), .pc_load_val(pc_load_val0),
        .in_isr(in_isr0), .ccr_restore(ccr_restore0), .ccr_restore_val(ccr_restore_val0)
    );

    // Stack pointer model (R3): push decrements, pop increments.
    always @(posedge clk) begin
        if (!rstn)              sp_value <= 8'hFF;
        else if (sp_en && !sp_op) sp_value <= sp_value - 8'd1;
        else if (sp_en && sp_op)  sp_value <= sp_value + 8'd1;
    end

    int n_pass  = 0;
    int n_total = 0;
    int ld_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        bit         is_load;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;
    exp_t sbq[$];
    exp_t e;

    task automatic expect_entry();
        sbq.push_back('{1'b0, sp_value, ret_pc});
`ifdef INT_CCR_SAVE_EN
        sbq.push_back('{1'b0, sp_value - 8'd1, {4'b0000, ccr_in}});
`endif
        sbq.push_back('{1'b1, VEC, ISR});
    endtask

    always @(negedge clk) begin
        if (rstn && bus.mem_b_sel && bus.mem_b_we) begin
            if (sbq.size() == 0) begin
                check("unexpected_write", {bus.mem_b_addr, bus.mem_b_wdata}, 32'hFFFF_FFFF);
            end else begin
                e = sbq.pop_front();
                check("push_write", {7'd0, 1'b0, sp_en, sp_op, bus.mem_b_addr, bus.mem_b_wdata},
                      {7'd0, e.is_load, 1'b1, 1'b0, e.addr, e.data});
            end
        end
        if (rstn && pc_load) begin
            ld_seen++;
            if (sbq.size() == 0) begin
                check("unexpected_load", {8'd0, pc_load_val}, 32'hFFFF_FFFF);
            end else begin
                e = sbq.pop_front();
                check("vector_load", {1'b1, pc_load_val, bus.mem_b_addr, bus.mem_b_we},
                      {e.is_load, e.data, e.addr, 1'b0});
            end
        end
    end

    function automatic logic [13:0] outs();
        return {pc_write_en, if_id_write_en, inject_bubble, bus.mem_b_sel, bus.mem_b_we,
                sp_en, sp_op, pc_load, in_isr, ccr_restore, ccr_restore_val};
    endfunction

    function automatic logic [13:0] mk(bit pw, bit ifid, bit bub, bit sel, bit we, bit spen,
                                       bit pcl, bit isr, bit ccr, logic [3:0] val);
        return {pw, ifid, bub, sel, we, spen, 1'b0, pcl, isr, ccr, val};
    endfunction

    typedef struct {
        logic        req;
        logic        rti;
        logic [13:0] exp;
    } vec_t;
    vec_t vt[$];

    task automatic wait_load(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (pc_load) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int stalls;
        int ld0;
        logic [13:0] o_idle, o_drain, o_push, o_vec;
        o_idle  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0);
        o_drain = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 4'h0);
        o_push  = mk(0, 0, 1, 1, 1, 1, 0, 0, 0, 4'h0);
        o_vec   = mk(0, 1, 1, 1, 0, 0, 1, 0, 0, 4'h0);

        rstn = 1'b0; int_req = 1'b0; rti_done = 1'b0; int_req0 = 1'b0; rti_done0 = 1'b0;
        ret_pc = 8'h2A; ccr_in = 4'b1010;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", outs(), o_idle);
        check("reset_state_d0", {pc_write_en0, if_id_write_en0, bus0.mem_b_sel, in_isr0}, 4'b1100);
        @(posedge clk); #1 rstn = 1'b1;

        // Entry sequence, one record per cycle.
        vt.push_back('{1'b1, 1'b0, o_idle});
        vt.push_back('{1'b0, 1'b0, o_idle});
        vt.push_back('{1'b0, 1'b0, o_drain});
        vt.push_back('{1'b0, 1'b0, o_drain});
        vt.push_back('{1'b0, 1'b0, o_drain});
        vt.push_back('{1'b0, 1'b0, o_push});
`ifdef INT_CCR_SAVE_EN
        vt.push_back('{1'b0, 1'b0, o_push});
`endif
        vt.push_back('{1'b0, 1'b0, o_vec});
        vt.push_back('{1'b0, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 4'h0)});
`ifdef INT_CCR_SAVE_EN
        vt.push_back('{1'b0, 1'b1, mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 4'b1010)});
`else
        vt.push_back('{1'b0, 1'b1, mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 4'h0)});
`endif
        vt.push_back('{1'b0, 1'b0, o_idle});

        expect_entry();
        for (int i = 0; i < vt.size(); i++) begin
            @(posedge clk); #1;
            int_req  = vt[i].req;
            rti_done = vt[i].rti;
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(), vt[i].exp);
        end
        @(posedge clk); #1 int_req = 1'b0; rti_done = 1'b0;

        // Reset while draining aborts the entry with no retry.
        @(posedge clk); #1 int_req = 1'b1;
        @(posedge clk); #1 int_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (inject_bubble) begin ok = 1'b1; break; end
        end
        check("drain_reached", ok, 1);
        @(posedge clk); #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_mid_drain", outs(), o_idle);
        @(posedge clk); #1 rstn = 1'b1;
        stalls = 0;
        repeat (8) begin @(negedge clk); if (!pc_write_en) stalls++; end
        check("no_resume_after_reset", stalls, 0);

        // Level-held request yields one entry; a rise during the ISR waits for RTI.
        ret_pc = 8'h33;
        expect_entry();
        ld0 = ld_seen;
        @(posedge clk); #1 int_req = 1'b1;
        repeat (20) @(posedge clk);
        #1 int_req = 1'b0;
        check("level_one_entry", ld_seen - ld0, 1);
        check("level_in_isr", in_isr, 1);
        ret_pc = 8'h44;
        @(posedge clk); #1 int_req = 1'b1;
        @(posedge clk); #1 int_req = 1'b0;
        stalls = 0;
        repeat (8) begin @(negedge clk); if (!pc_write_en) stalls++; end
        check("no_nesting", stalls, 0);
        expect_entry();
        @(posedge clk); #1 rti_done = 1'b1;
        @(posedge clk); #1 rti_done = 1'b0;
        wait_load(20, ok);
        check("deferred_serviced", ok, 1);
        @(negedge clk);
        check("deferred_in_isr", in_isr, 1);

        // RTI and a new rise in the same cycle.
        ret_pc = 8'h55;
        @(posedge clk); #1 rti_done = 1'b1; int_req = 1'b1;
        @(negedge clk);
        check("simul_isr_held", in_isr, 1);
        @(posedge clk); #1 rti_done = 1'b0; int_req = 1'b0;
        expect_entry();
        @(negedge clk);
        check("simul_isr_cleared", {in_isr, inject_bubble, pc_write_en}, 3'b001);
        @(negedge clk);
        check("simul_restart", {in_isr, inject_bubble, pc_write_en}, 3'b010);
        wait_load(20, ok);
        check("simul_serviced", ok, 1);
        @(posedge clk); #1 rti_done = 1'b1;
        @(posedge clk); #1 rti_done = 1'b0;
        @(negedge clk);
        check("simul_rti_clear", in_isr, 0);

        // Zero-drain instance: push two edges after the rise.
        ret_pc = 8'h66;
        @(posedge clk); #1 int_req0 = 1'b1;
        @(negedge clk);
        check("d0_before_edge", pc_write_en0, 1);
        @(posedge clk); #1 int_req0 = 1'b0;
        @(negedge clk);
        check("d0_pending_edge", {pc_write_en0, bus0.mem_b_we}, 2'b10);
        @(negedge clk);
        check("d0_push", {pc_write_en0, bus0.mem_b_we, sp_en0, sp_op0, bus0.mem_b_addr, bus0.mem_b_wdata},
              {4'b0110, 8'h40, 8'h66});
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (pc_load0) begin ok = 1'b1; break; end
        end
        check("d0_vector", {ok, pc_load_val0}, {1'b1, ISR});
        @(posedge clk); #1 rti_done0 = 1'b1;
        @(posedge clk); #1 rti_done0 = 1'b0;
        @(negedge clk);
        check("d0_rti_clear", in_isr0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
